// File: rtl/bk_spi_master_if.sv
// CPU-side strobe/data and SPI pin bundle for bk_spi_master.
// The master modport is the engine's view; slave is the CPU/pin side.
interface bk_spi_master_if;
  logic       wren;
  logic [7:0] din;
  logic       cs_n_i;
  logic [7:0] dout;
  logic       dsr;
  logic       ovr;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       ss_n;

  modport master (
    input  wren, din, cs_n_i, miso,
    output dout, dsr, ovr, sclk, mosi, ss_n
  );

  modport slave (
    output wren, din, cs_n_i, miso,
    input  dout, dsr, ovr, sclk, mosi, ss_n
  );
endinterface

// File: rtl/bk_spi_master.sv
// Byte-wide SPI mode-0 master, MSB first, with a ce-qualified SCLK divider.
// One transfer spans 16 half-periods of CLKDIV ce cycles each.
module bk_spi_master #(
  parameter int CLKDIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  bk_spi_master_if.master  bus
);

  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t     state;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [6:0] tx_sr;
  logic [7:0] rx_sr;
  logic [7:0] dout_q;
  logic       dsr_q;
  logic       ovr_q;
  logic       sclk_q;
  logic       mosi_q;
  logic       ss_n_q;
  logic       div_done;

  assign div_done = (div_cnt == DIV_LAST);

  // Chip select is a plain one-cycle register of the CPU request, independent of ce.
  always_ff @(posedge clk) begin
    if (reset) ss_n_q <= 1'b1;
    else       ss_n_q <= bus.cs_n_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      dsr_q   <= 1'b1;
      ovr_q   <= 1'b0;
      dout_q  <= 8'hFF;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (bus.wren) begin
            mosi_q  <= bus.din[7];
            dsr_q   <= 1'b0;
            ovr_q   <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= LOW;
          end
        end
        LOW: begin
          if (bus.wren) ovr_q <= 1'b1;
          if (div_done) begin
            sclk_q  <= 1'b1;
            div_cnt <= '0;
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HIGH: begin
          // A strobe on the completing edge still counts as busy.
          if (bus.wren) ovr_q <= 1'b1;
          if (div_done) begin
            sclk_q  <= 1'b0;
            div_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              mosi_q <= 1'b1;
              dout_q <= rx_sr;
              dsr_q  <= 1'b1;
              state  <= IDLE;
            end else begin
              mosi_q  <= tx_sr[6];
              bit_cnt <= bit_cnt + 3'd1;
              state   <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift registers carry data only; every transfer reloads or fully refills them.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (state == IDLE && bus.wren) begin
        tx_sr <= bus.din[6:0];
      end else if (state == HIGH && div_done && bit_cnt != 3'd7) begin
        tx_sr <= {tx_sr[5:0], 1'b0};
      end
      if (state == LOW && div_done) begin
        rx_sr <= {rx_sr[6:0], bus.miso};
      end
    end
  end

  assign bus.dout = dout_q;
  assign bus.dsr  = dsr_q;
  assign bus.ovr  = ovr_q;
  assign bus.sclk = sclk_q;
  assign bus.mosi = mosi_q;
  assign bus.ss_n = ss_n_q;

endmodule
